// File: rtl/mux_pipe_n_pkg.sv
// Shared definitions for the N-channel pipelined multiplexer: mode encodings,
// legal channel-count range and the round-robin pointer advance helper.
package mux_pipe_n_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 16;

  // Pointer moves one past the channel that was just served, wrapping at nch.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned nch);
    return (idx + 1 >= nch) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_pipe_n_if.sv
// Handshake bundle between the channel sources/sink and mux_pipe_n.
// The master side drives the channel inputs and the downstream ready.
interface mux_pipe_n_if
  import mux_pipe_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  mode_e                mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_pipe_n_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at
// or after ptr, wrapping to the lowest requester when none is found above it.
module rr_arbiter
  import mux_pipe_n_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant
);

  logic [NCH-1:0] mask;
  logic [NCH-1:0] req_hi;
  logic [NCH-1:0] pick_hi;
  logic [NCH-1:0] pick_all;

  // Channels at or above the pointer have priority over the wrapped ones.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
    assign mask[gi] = (SELW'(gi) >= ptr);
  end

  assign req_hi   = req & mask;
  // Lowest set bit isolation: x & (-x).
  assign pick_hi  = req_hi & (~req_hi + NCH'(1));
  assign pick_all = req & (~req + NCH'(1));
  assign grant    = (|req_hi) ? pick_hi : pick_all;

endmodule

// File: rtl/mux_pipe_n.sv
// N-channel multiplexer with fixed or round-robin channel selection feeding a
// single registered output stage with ready/valid flow control.
module mux_pipe_n
  import mux_pipe_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          reset,
  mux_pipe_n_if.slave   bus
);

  logic [SELW-1:0]  ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_ch_reg;

  logic             can_load;
  logic [NCH-1:0]   rr_grant;
  logic [NCH-1:0]   fixed_grant;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   in_ready;
  logic             in_fire;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  ptr_next;

  assign can_load = !out_valid_reg || bus.out_ready;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req   (bus.in_valid),
    .ptr   (ptr_reg),
    .grant (rr_grant)
  );

  // An out-of-range sel matches no channel, so the fixed grant is all-zero.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_fixed
    assign fixed_grant[gi] = (bus.sel == SELW'(gi));
  end

  assign grant    = (bus.mode == MODE_RR) ? rr_grant : fixed_grant;
  // Reset forces ready low combinationally, independent of the clock.
  assign in_ready = grant & {NCH{can_load & ~reset}};
  assign in_fire  = |(in_ready & bus.in_valid);

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant[k]) begin
        grant_idx = SELW'(k);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NCH; k++) begin
      grant_data = grant_data | (bus.in_data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
    end
  end

  assign ptr_next = SELW'(next_ptr(32'(grant_idx), NCH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else begin
      if (in_fire) begin
        out_data_reg  <= grant_data;
        out_ch_reg    <= grant_idx;
        out_valid_reg <= 1'b1;
        if (bus.mode == MODE_RR) begin
          ptr_reg <= ptr_next;
        end
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Self-checking bench for mux_pipe_n: directed scenarios plus randomized
// traffic against a behavioural channel-search model (NCH=4) and an NCH=3 copy.
module tb_mux_pipe_n;
  import mux_pipe_n_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_pipe_n_if #(.WIDTH(W),  .NCH(N))  bus4 ();
  mux_pipe_n_if #(.WIDTH(W3), .NCH(N3)) bus3 ();

  mux_pipe_n #(.WIDTH(W),  .NCH(N))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  mux_pipe_n #(.WIDTH(W3), .NCH(N3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_ch;
  bit          chk3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_ch = 0;
  endtask

  // Expected ready vector derived from the selection rules.
  function automatic logic [N-1:0] exp_ready();
    int k;
    if (reset) return '0;
    if (m_valid && !bus4.out_ready) return '0;
    if (bus4.mode == MODE_FIXED) begin
      if (int'(bus4.sel) < N) return N'(1) << bus4.sel;
      return '0;
    end
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (bus4.in_valid[k]) return N'(1) << k;
    end
    return '0;
  endfunction

  task automatic drive4(input bit md, input int s, input logic [N-1:0] v, input bit ordy);
    bus4.mode      = mode_e'(md);
    bus4.sel       = 2'(s);
    bus4.in_valid  = v;
    bus4.out_ready = ordy;
    for (int k = 0; k < N; k++) bus4.in_data[k*W +: W] = $urandom();
  endtask

  // Called just after a rising edge: check ready mid-cycle, clock, check outputs.
  task automatic cycle4(input string tag);
    logic [N-1:0] g;
    int           gi;
    bit           fire;
    bit           ordy;
    logic [31:0]  d;
    #4;
    g = exp_ready();
    chk({tag, "/in_ready"}, bus4.in_ready, g);
    fire = 0; gi = 0; d = '0;
    for (int k = 0; k < N; k++) begin
      if (g[k] && bus4.in_valid[k]) begin
        fire = 1; gi = k; d = bus4.in_data[k*W +: W];
      end
    end
    ordy = bus4.out_ready;
    if (chk3) begin
      chk({tag, "/n3_ready"}, bus3.in_ready, 0);
    end
    @(posedge clk);
    #1;
    if (fire) begin
      m_valid = 1; m_data = d; m_ch = gi;
      if (bus4.mode == MODE_RR) m_ptr = (gi + 1) % N;
    end else if (ordy) begin
      m_valid = 0;
    end
    chk({tag, "/out_valid"}, bus4.out_valid, m_valid);
    chk({tag, "/out_ch"},    bus4.out_ch,    m_ch);
    chk({tag, "/out_data"},  bus4.out_data,  m_data);
    if (chk3) begin
      chk({tag, "/n3_valid"}, bus3.out_valid, 0);
    end
    $display("txn %s mode=%0d sel=%0d valid=%b ordy=%0d fire=%0d ch=%0d data=%h ptr=%0d",
             tag, bus4.mode, bus4.sel, bus4.in_valid, ordy, fire, m_ch, m_data, m_ptr);
  endtask

  initial begin
    logic [N3-1:0] r3;
    logic [7:0]    d3;
    int rr_seq [5] = '{0, 1, 2, 3, 0};

    chk3 = 1;
    model_reset();
    reset = 1'b1;
    drive4(1'b0, 2, 4'b1111, 1'b1);
    bus3.mode = MODE_FIXED; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    bus3.in_data = 24'hA5C33C;

    // Reset state with the clock running
    repeat (2) @(posedge clk);
    #1;
    chk("rst/in_ready",  bus4.in_ready,  0);
    chk("rst/out_valid", bus4.out_valid, 0);
    chk("rst/out_data",  bus4.out_data,  0);
    chk("rst/out_ch",    bus4.out_ch,    0);
    chk("rst/n3_ready",  bus3.in_ready,  0);
    reset = 1'b0;

    // Fixed selection, first transfer on the first edge after reset
    drive4(1'b0, 2, 4'b1111, 1'b1);
    bus4.in_data[2*W +: W] = 32'hDEADBEEF;
    cycle4("fixed_sel2");
    chk("fixed_sel2/data_const", bus4.out_data, 32'hDEADBEEF);
    chk("fixed_sel2/ch_const",   bus4.out_ch,   2);

    // Round robin from ptr 0 with all channels requesting
    for (int i = 0; i < 5; i++) begin
      drive4(1'b1, 0, 4'b1111, 1'b1);
      cycle4("rr_all");
      chk("rr_all/seq", bus4.out_ch, rr_seq[i]);
    end

    // Move ptr to 2, then sparse requesters 1 and 3
    drive4(1'b1, 0, 4'b0010, 1'b1);
    cycle4("rr_to_p2");
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 0, 4'b1010, 1'b1);
      cycle4("rr_sparse");
      chk("rr_sparse/seq", bus4.out_ch, (i % 2 == 0) ? 3 : 1);
    end

    // Backpressure: held beat stays put, sel/mode changes do not disturb it
    for (int i = 0; i < 3; i++) begin
      drive4(i[0], i, 4'b1111, 1'b0);
      cycle4("bp_hold");
    end
    drive4(1'b1, 0, 4'b1111, 1'b1);
    cycle4("bp_release");
    drive4(1'b1, 0, 4'b1111, 1'b1);
    cycle4("bp_stream");

    // No requests in RR: output drains, data/channel hold
    for (int i = 0; i < 2; i++) begin
      drive4(1'b1, 0, 4'b0000, 1'b1);
      cycle4("rr_idle");
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive4(1'($urandom_range(0, 1)), $urandom_range(0, 3), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) != 0));
      cycle4("rand");
    end

    // Reach ptr=2 with a pending beat, then pulse reset mid-cycle
    drive4(1'b1, 0, 4'b0000, 1'b1);
    cycle4("pre_rst_drain");
    drive4(1'b1, 0, 4'b0010, 1'b1);
    cycle4("pre_rst_p2");
    drive4(1'b1, 0, 4'b1111, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst/out_valid", bus4.out_valid, 0);
    chk("midrst/out_data",  bus4.out_data,  0);
    chk("midrst/out_ch",    bus4.out_ch,    0);
    chk("midrst/in_ready",  bus4.in_ready,  0);
    #1;
    reset = 1'b0;
    model_reset();
    $display("txn midrst reset pulse applied");
    drive4(1'b1, 0, 4'b0000, 1'b0);
    cycle4("post_rst_idle");
    drive4(1'b1, 0, 4'b1111, 1'b0);
    cycle4("post_rst_ptr0");
    chk("post_rst_ptr0/ch_const", bus4.out_ch, 0);

    // NCH=3: a legal select now passes data through
    chk3 = 0;
    bus3.sel = 2'd1;
    bus3.in_data = 24'h5AF00F;
    d3 = 8'hF0;
    #4;
    r3 = bus3.in_ready;
    chk("n3_sel1/in_ready", r3, 3'b010);
    @(posedge clk);
    #1;
    chk("n3_sel1/out_valid", bus3.out_valid, 1);
    chk("n3_sel1/out_ch",    bus3.out_ch,    1);
    chk("n3_sel1/out_data",  bus3.out_data,  d3);
    $display("txn n3_sel1 ch=%0d data=%h", bus3.out_ch, bus3.out_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
